// File: rtl/arithmetic_inverse_div.sv
// Recovers S = (Y - D) / C and the remainder using a multi-cycle restoring divider
// behind valid/ready handshakes. Optional `exact` output enabled by ARITH_INV_EXACT_EN.
module arithmetic_inverse_div #(
  parameter int DATA_W = 16,
  parameter int OP_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] Y,
  input  logic [OP_W-1:0]   C,
  input  logic [OP_W-1:0]   D,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] quot,
  output logic [DATA_W-1:0] rem,
  output logic              q_ovf,
  output logic [1:0]        err
`ifdef ARITH_INV_EXACT_EN
  ,
  output logic              exact
`endif
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, PREP, DIV, DONE} state_t;
  state_t state, state_nxt;

  logic [DATA_W-1:0] y_r;
  logic [OP_W-1:0]   c_r, d_r;
  logic [DATA_W-1:0] dvd, qacc, prem;
  logic [CNT_W-1:0]  cnt;

  logic [DATA_W:0]   diff;
  logic              underflow, div_zero;
  logic [DATA_W:0]   shifted, divisor, trial, prem_nxt;
  logic              qbit;
  logic [DATA_W-1:0] quot_fin;

  logic              load_out;
  logic [DATA_W-1:0] quot_nxt, rem_nxt;
  logic              q_ovf_nxt;
  logic [1:0]        err_nxt;
  logic [1:0]        unused_bits;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  assign diff      = {1'b0, y_r} - {{(DATA_W+1-OP_W){1'b0}}, d_r};
  assign underflow = diff[DATA_W];
  assign div_zero  = (c_r == '0);

  // One restoring step: bring in the next dividend bit and subtract if it fits.
  assign shifted  = {prem, dvd[DATA_W-1]};
  assign divisor  = {{(DATA_W+1-OP_W){1'b0}}, c_r};
  assign qbit     = (shifted >= divisor);
  assign trial    = shifted - divisor;
  assign prem_nxt = qbit ? trial : shifted;
  assign quot_fin = {qacc[DATA_W-2:0], qbit};

  // Partial remainder stays below C, so these top bits are always zero.
  assign unused_bits = {prem_nxt[DATA_W], qacc[DATA_W-1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_out  = 1'b0;
    quot_nxt  = '0;
    rem_nxt   = '0;
    q_ovf_nxt = 1'b0;
    err_nxt   = 2'b00;
    case (state)
      IDLE: if (in_valid) state_nxt = PREP;
      PREP: begin
        if (underflow) begin
          state_nxt = DONE;
          load_out  = 1'b1;
          err_nxt   = 2'b10;
        end else if (div_zero) begin
          state_nxt = DONE;
          load_out  = 1'b1;
          err_nxt   = 2'b01;
          quot_nxt  = '1;
          rem_nxt   = diff[DATA_W-1:0];
          q_ovf_nxt = 1'b1;
        end else begin
          state_nxt = DIV;
        end
      end
      DIV: begin
        if (cnt == '0) begin
          state_nxt = DONE;
          load_out  = 1'b1;
          quot_nxt  = quot_fin;
          rem_nxt   = prem_nxt[DATA_W-1:0];
          q_ovf_nxt = |quot_fin[DATA_W-1:OP_W];
        end
      end
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_r   <= '0;
      c_r   <= '0;
      d_r   <= '0;
      dvd   <= '0;
      qacc  <= '0;
      prem  <= '0;
      cnt   <= '0;
      quot  <= '0;
      rem   <= '0;
      q_ovf <= 1'b0;
      err   <= 2'b00;
`ifdef ARITH_INV_EXACT_EN
      exact <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            y_r <= Y;
            c_r <= C;
            d_r <= D;
          end
        end
        PREP: begin
          dvd  <= diff[DATA_W-1:0];
          prem <= '0;
          qacc <= '0;
          cnt  <= CNT_W'(DATA_W-1);
        end
        DIV: begin
          dvd  <= {dvd[DATA_W-2:0], 1'b0};
          prem <= prem_nxt[DATA_W-1:0];
          qacc <= quot_fin;
          cnt  <= cnt - 1'b1;
        end
        default: ;
      endcase
      if (load_out) begin
        quot  <= quot_nxt;
        rem   <= rem_nxt;
        q_ovf <= q_ovf_nxt;
        err   <= err_nxt;
`ifdef ARITH_INV_EXACT_EN
        exact <= (err_nxt == 2'b00) && (rem_nxt == '0) && !q_ovf_nxt;
`endif
      end
    end
  end

endmodule

// File: tb/tb_arithmetic_inverse_div.sv
// Self-checking bench for arithmetic_inverse_div: transaction-level reference model,
// per-cycle compare process, directed test-plan vectors and randomized traffic.
module tb_arithmetic_inverse_div;
  localparam int DATA_W = 16;
  localparam int OP_W   = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] Y = '0;
  logic [OP_W-1:0]   C = '0;
  logic [OP_W-1:0]   D = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] quot, rem;
  logic              q_ovf;
  logic [1:0]        err;
`ifdef ARITH_INV_EXACT_EN
  logic              exact;
`endif

  int checks = 0;
  int errors = 0;

  arithmetic_inverse_div #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .Y(Y), .C(C), .D(D),
    .out_valid(out_valid), .out_ready(out_ready),
    .quot(quot), .rem(rem), .q_ovf(q_ovf), .err(err)
`ifdef ARITH_INV_EXACT_EN
    , .exact(exact)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] r;
    logic [1:0]        e;
    logic              ov;
    logic              ex;
    int                lat;
  } res_t;

  function automatic res_t zero_res();
    res_t z;
    z.q = '0; z.r = '0; z.e = 2'b00; z.ov = 1'b0; z.ex = 1'b0; z.lat = 0;
    return z;
  endfunction

  // Expected result straight from the arithmetic definition.
  function automatic res_t model(input int unsigned y, input int unsigned c, input int unsigned d);
    res_t m;
    if (y < d) begin
      m.e = 2'b10; m.q = '0; m.r = '0; m.ov = 1'b0; m.lat = 1;
    end else if (c == 0) begin
      m.e = 2'b01; m.q = '1; m.r = DATA_W'(y - d); m.ov = 1'b1; m.lat = 1;
    end else begin
      m.e = 2'b00;
      m.q = DATA_W'((y - d) / c);
      m.r = DATA_W'((y - d) % c);
      m.ov = (((y - d) / c) >= (32'd1 << OP_W));
      m.lat = DATA_W + 1;
    end
    m.ex = (m.e == 2'b00) && (m.r == '0) && !m.ov;
    return m;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model of the handshake timing.
  bit   busy = 1'b0;
  int   cyc = 0;
  res_t cur = zero_res();
  res_t shown = zero_res();

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy = 1'b0; cyc = 0; shown = zero_res();
    end else if (!busy) begin
      if (in_valid) begin
        cur = model(Y, C, D);
        busy = 1'b1;
        cyc = 0;
      end
    end else if (cyc >= cur.lat) begin
      if (out_ready) busy = 1'b0;
    end else begin
      cyc++;
      if (cyc == cur.lat) shown = cur;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", 64'(in_ready), 64'(!busy));
      chk("out_valid", 64'(out_valid), 64'(busy && (cyc >= cur.lat)));
      chk("quot", 64'(quot), 64'(shown.q));
      chk("rem", 64'(rem), 64'(shown.r));
      chk("err", 64'(err), 64'(shown.e));
      chk("q_ovf", 64'(q_ovf), 64'(shown.ov));
`ifdef ARITH_INV_EXACT_EN
      chk("exact", 64'(exact), 64'(shown.ex));
`endif
    end
  end

  task automatic send(input int unsigned y, input int unsigned c, input int unsigned d,
                      input int hold, input bit poke, output res_t got);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b1; Y = DATA_W'(y); C = OP_W'(c); D = OP_W'(d);
    @(negedge clk);
    in_valid = 1'b0; Y = DATA_W'($urandom); C = OP_W'($urandom); D = OP_W'($urandom);
    n = 0;
    while (!out_valid && n < 60) begin @(negedge clk); n++; end
    if (!out_valid) chk("done_timeout", 64'(out_valid), 64'd1);
    got.q = quot; got.r = rem; got.e = err; got.ov = q_ovf; got.lat = n;
`ifdef ARITH_INV_EXACT_EN
    got.ex = exact;
`else
    got.ex = 1'b0;
`endif
    in_valid = poke;
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    res_t g, m;

    // Pin the model against hand-computed values.
    m = model(21, 4, 1);     chk("pin_q_21", 64'(m.q), 64'd5);
    m = model(99, 7, 2);     chk("pin_r_99", 64'(m.r), 64'd6);
    m = model(50, 0, 10);    chk("pin_r_50", 64'(m.r), 64'd40);
    m = model(65535, 1, 0);  chk("pin_ov_65535", 64'(m.ov), 64'd1);

    #12 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_quot", 64'(quot), 64'd0);
    chk("rst_err", 64'(err), 64'd0);

    send(21, 4, 1, 0, 1'b0, g);
    chk("t1_quot", 64'(g.q), 64'd5);
    chk("t1_rem", 64'(g.r), 64'd0);
    chk("t1_err", 64'(g.e), 64'd0);
    chk("t1_ovf", 64'(g.ov), 64'd0);
    chk("t1_lat", 64'(g.lat), 64'd17);
`ifdef ARITH_INV_EXACT_EN
    chk("t1_exact", 64'(g.ex), 64'd1);
`endif

    send(99, 7, 2, 5, 1'b1, g);
    chk("t2_quot", 64'(g.q), 64'd13);
    chk("t2_rem", 64'(g.r), 64'd6);
    chk("t2_err", 64'(g.e), 64'd0);
`ifdef ARITH_INV_EXACT_EN
    chk("t2_exact", 64'(g.ex), 64'd0);
`endif
    chk("bp_in_ready_after", 64'(in_ready), 64'd1);

    send(3, 2, 5, 0, 1'b0, g);
    chk("t3_err", 64'(g.e), 64'd2);
    chk("t3_quot", 64'(g.q), 64'd0);
    chk("t3_rem", 64'(g.r), 64'd0);
    chk("t3_lat", 64'(g.lat), 64'd1);

    send(50, 0, 10, 2, 1'b0, g);
    chk("t4_err", 64'(g.e), 64'd1);
    chk("t4_quot", 64'(g.q), 64'hFFFF);
    chk("t4_rem", 64'(g.r), 64'd40);
    chk("t4_ovf", 64'(g.ov), 64'd1);

    send(65535, 1, 0, 0, 1'b0, g);
    chk("t5_quot", 64'(g.q), 64'd65535);
    chk("t5_ovf", 64'(g.ov), 64'd1);
    chk("t5_err", 64'(g.e), 64'd0);

    // Randomized traffic with biased corner cases and random backpressure.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 4))
        0: C = '0;
        1: C = 8'd1;
        default: C = OP_W'($urandom);
      endcase
      if ($urandom_range(0, 3) == 0) Y = DATA_W'($urandom_range(0, 300));
      else Y = DATA_W'($urandom);
      D = OP_W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (40) @(negedge clk);
    out_ready = 1'b0;

    // Asynchronous reset in the middle of DIV.
    in_valid = 1'b1; Y = 16'd1000; C = 8'd7; D = 8'd0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_quot", 64'(quot), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    #8 rst = 1'b0;
    @(negedge clk);
    send(26, 3, 2, 0, 1'b0, g);
    chk("t6_quot", 64'(g.q), 64'd8);
    chk("t6_rem", 64'(g.r), 64'd0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
